// File: rtl/spi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_responder
// Brief    : SPI slave that oversamples SCLK/CS/MOSI in the pclk domain and
//            exchanges tx/rx words over valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================

module spi_slave_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int                 c_CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);
  localparam logic               c_IDLE_LVL = (CPOL != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;

  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_tx_ready;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic [c_CNT_W-1:0]    r_bit_cnt;
  logic                  r_reload;
  logic                  r_hold_first;
  logic                  r_miso;
  logic                  r_miso_oe;
  logic                  r_rx_overrun;
  logic                  r_tx_underrun;
  logic                  r_busy;

  logic                  w_sclk_s;
  logic                  w_cs_s;
  logic                  w_mosi_s;
  logic                  w_lead;
  logic                  w_trail;
  logic                  w_sample_edge;
  logic                  w_shift_edge;
  logic                  w_do_sample;
  logic                  w_do_shift;
  logic                  w_push;
  logic                  w_consume;
  logic [DATA_WIDTH-1:0] w_load_word;
  logic [DATA_WIDTH-1:0] w_tx_shifted;
  logic [DATA_WIDTH-1:0] w_rx_next;
  logic                  w_load_head;
  logic                  w_tx_head;
  logic                  w_shift_head;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  assign w_lead        = (w_sclk_s != c_IDLE_LVL) && (r_sclk_prev == c_IDLE_LVL);
  assign w_trail       = (w_sclk_s == c_IDLE_LVL) && (r_sclk_prev != c_IDLE_LVL);
  assign w_sample_edge = (CPHA == 0) ? w_lead  : w_trail;
  assign w_shift_edge  = (CPHA == 0) ? w_trail : w_lead;

  // A sample coinciding with the cs rise still completes the word; a shift does not.
  assign w_do_sample = (r_state == ST_SHIFT) && w_sample_edge;
  assign w_do_shift  = (r_state == ST_SHIFT) && w_shift_edge && !w_cs_s;

  assign w_push      = tx_valid && r_tx_ready;
  assign w_consume   = (r_state == ST_LOAD) || (w_do_shift && r_reload);
  assign w_load_word = r_tx_ready ? '0 : r_hold;

  if (MSB_FIRST != 0) begin : g_msb_first
    assign w_tx_shifted = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
    assign w_shift_head = r_tx_shift[DATA_WIDTH-2];
    assign w_tx_head    = r_tx_shift[DATA_WIDTH-1];
    assign w_load_head  = w_load_word[DATA_WIDTH-1];
    assign w_rx_next    = {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
  end else begin : g_lsb_first
    assign w_tx_shifted = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
    assign w_shift_head = r_tx_shift[1];
    assign w_tx_head    = r_tx_shift[0];
    assign w_load_head  = w_load_word[0];
    assign w_rx_next    = {w_mosi_s, r_rx_shift[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      r_sclk_sync <= {SYNC_STAGES{c_IDLE_LVL}};
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= c_IDLE_LVL;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_prev <= w_sclk_s;
    end
  end

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (!w_cs_s) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = w_cs_s ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: if (w_cs_s) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      r_hold        <= '0;
      r_tx_ready    <= 1'b1;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_bit_cnt     <= '0;
      r_reload      <= 1'b0;
      r_hold_first  <= 1'b0;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_busy        <= (w_state_next != ST_IDLE);

      if (w_push) begin
        r_hold     <= tx_data;
        r_tx_ready <= 1'b0;
      end else if (w_consume) begin
        r_tx_ready <= 1'b1;
      end

      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;

      case (r_state)
        ST_LOAD: begin
          r_tx_shift    <= w_load_word;
          r_tx_underrun <= r_tx_ready;
          r_miso_oe     <= 1'b1;
          r_bit_cnt     <= '0;
          r_reload      <= 1'b0;
          r_rx_shift    <= '0;
          r_hold_first  <= (CPHA != 0);
          if (CPHA == 0) r_miso <= w_load_head;
        end
        ST_SHIFT: begin
          if (w_do_sample) begin
            r_rx_shift <= w_rx_next;
            if (r_bit_cnt == c_LAST_BIT) begin
              r_rx_data    <= w_rx_next;
              r_rx_valid   <= 1'b1;
              r_rx_overrun <= r_rx_valid && !rx_ready;
              r_bit_cnt    <= '0;
              r_reload     <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          // CPHA=1 drives the already-loaded first bit on the first leading edge.
          if (w_do_shift) begin
            if (r_reload) begin
              r_tx_shift    <= w_load_word;
              r_miso        <= w_load_head;
              r_tx_underrun <= r_tx_ready;
              r_reload      <= 1'b0;
            end else if (r_hold_first) begin
              r_miso       <= w_tx_head;
              r_hold_first <= 1'b0;
            end else begin
              r_tx_shift <= w_tx_shifted;
              r_miso     <= w_shift_head;
            end
          end
        end
        default: ;
      endcase

      if ((r_state != ST_IDLE) && w_cs_s) begin
        r_miso_oe    <= 1'b0;
        r_miso       <= 1'b0;
        r_bit_cnt    <= '0;
        r_reload     <= 1'b0;
        r_hold_first <= 1'b0;
      end
    end
  end

  assign miso        = r_miso;
  assign miso_oe     = r_miso_oe;
  assign tx_ready    = r_tx_ready;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_rx_overrun;
  assign tx_underrun = r_tx_underrun;
  assign busy        = r_busy;

endmodule

`default_nettype wire
